// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared encodings for the hazard controller: instruction classes,
// forwarding-mux selects, multi-cycle FSM states and a width helper.
package hazard_ctrl_mc_pkg;

    localparam int INST_W = 3;
    localparam int FWD_W  = 2;

    localparam logic [INST_W-1:0] INST_R      = 3'd0;
    localparam logic [INST_W-1:0] INST_I      = 3'd1;
    localparam logic [INST_W-1:0] INST_LW     = 3'd2;
    localparam logic [INST_W-1:0] INST_SW     = 3'd3;
    localparam logic [INST_W-1:0] INST_BEQ    = 3'd4;
    localparam logic [INST_W-1:0] INST_J      = 3'd5;
    localparam logic [INST_W-1:0] INST_JR     = 3'd6;
    localparam logic [INST_W-1:0] INST_MULDIV = 3'd7;

    localparam logic [FWD_W-1:0] EXE_NOFWD   = 2'd0;
    localparam logic [FWD_W-1:0] MEM2EXE_FWD = 2'd1;
    localparam logic [FWD_W-1:0] WB2EXE_FWD  = 2'd2;
    localparam logic [FWD_W-1:0] ID_NOFWD    = 2'd0;
    localparam logic [FWD_W-1:0] MEM2ID_FWD  = 2'd1;
    localparam logic [FWD_W-1:0] WB2ID_FWD   = 2'd2;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // Busy-counter width; at least one bit so MC_LAT of 1 or 2 stays legal.
    function automatic int unsigned mc_cnt_width(input int unsigned lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_mc_if
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0]  rs_ID;
    logic [REG_W-1:0]  rt_ID;
    logic              s_b_ID;
    logic [INST_W-1:0] inst_type_ID;
    logic [INST_W-1:0] inst_type_EXE;
    logic [INST_W-1:0] inst_type_MEM;
    logic              zero_ID;
    logic [REG_W-1:0]  rs_EXE;
    logic [REG_W-1:0]  rt_EXE;
    logic [REG_W-1:0]  num_write_EXE;
    logic              reg_write_MEM;
    logic              reg_write_WB;
    logic [REG_W-1:0]  num_write_MEM;
    logic [REG_W-1:0]  num_write_WB;

    logic [FWD_W-1:0]  s_a_FWD_EXE;
    logic [FWD_W-1:0]  s_b_FWD_EXE;
    logic [FWD_W-1:0]  s_a_FWD_ID;
    logic [FWD_W-1:0]  s_b_FWD_ID;
    logic              nWrite_PC;
    logic              nWrite_IF_ID;
    logic              nWrite_ID_EXE;
    logic              flush_IF_ID;
    logic              flush_ID_EXE;
    logic              flush_EXE_MEM;
    logic              mc_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs_ID, rt_ID, s_b_ID, inst_type_ID, inst_type_EXE, inst_type_MEM,
               zero_ID, rs_EXE, rt_EXE, num_write_EXE, reg_write_MEM, reg_write_WB,
               num_write_MEM, num_write_WB,
        input  s_a_FWD_EXE, s_b_FWD_EXE, s_a_FWD_ID, s_b_FWD_ID, nWrite_PC,
               nWrite_IF_ID, nWrite_ID_EXE, flush_IF_ID, flush_ID_EXE, flush_EXE_MEM,
               mc_busy, stall_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, s_b_ID, inst_type_ID, inst_type_EXE, inst_type_MEM,
               zero_ID, rs_EXE, rt_EXE, num_write_EXE, reg_write_MEM, reg_write_WB,
               num_write_MEM, num_write_WB,
        output s_a_FWD_EXE, s_b_FWD_EXE, s_a_FWD_ID, s_b_FWD_ID, nWrite_PC,
               nWrite_IF_ID, nWrite_ID_EXE, flush_IF_ID, flush_ID_EXE, flush_EXE_MEM,
               mc_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_mc_fsm.sv
// Multi-cycle EXE occupancy tracker: stalls the front end for MC_LAT-1
// cycles once a mul/div reaches EXE, then releases for one BUSY cycle.
module mc_stall_fsm
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_type_EXE,
    output logic              mc_stall,
    output logic              mc_busy
);
    localparam int CW = mc_cnt_width(MC_LAT);

    mc_state_t       state, state_next;
    logic [CW-1:0]   mc_cnt, mc_cnt_next;
    logic            stall_raw;

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MC_IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_next;
            mc_cnt <= mc_cnt_next;
        end
    end

    // Trigger from IDLE, count down in BUSY; the mc_cnt==0 cycle is the release.
    always_comb begin
        state_next  = state;
        mc_cnt_next = mc_cnt;
        stall_raw   = 1'b0;
        case (state)
            MC_IDLE: begin
                if (inst_type_EXE == INST_MULDIV && MC_LAT > 1) begin
                    state_next  = MC_BUSY;
                    mc_cnt_next = CW'(MC_LAT - 2);
                    stall_raw   = 1'b1;
                end
            end
            MC_BUSY: begin
                if (mc_cnt == '0) begin
                    state_next = MC_IDLE;
                end else begin
                    mc_cnt_next = mc_cnt - CW'(1);
                    stall_raw   = 1'b1;
                end
            end
            default: state_next = MC_IDLE;
        endcase
    end

    // Reset releases the stall in the same cycle it is asserted.
    assign mc_stall = stall_raw && !rst;
    assign mc_busy  = (state == MC_BUSY) && !rst;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: EXE/ID forwarding, mul/div freeze, branch/JR and
// load-use stalls, control flushes and a saturating stall counter.
module hazard_ctrl_mc
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             rst,
    hazard_ctrl_mc_if.slave hz
);
    logic             mc_stall;
    logic             mem_ok, wb_ok;
    logic             br_stall, lu_stall, ctrl_flush, is_br;
    logic [CNT_W-1:0] cnt_q;

    mc_stall_fsm #(.MC_LAT(MC_LAT)) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .inst_type_EXE (hz.inst_type_EXE),
        .mc_stall      (mc_stall),
        .mc_busy       (hz.mc_busy)
    );

    assign mem_ok = hz.reg_write_MEM && (hz.num_write_MEM != REG_W'(0));
    assign wb_ok  = hz.reg_write_WB  && (hz.num_write_WB  != REG_W'(0));

    // Forwarding selects: MEM result beats WB result for every operand.
    always_comb begin
        hz.s_a_FWD_EXE = EXE_NOFWD;
        hz.s_b_FWD_EXE = EXE_NOFWD;
        hz.s_a_FWD_ID  = ID_NOFWD;
        hz.s_b_FWD_ID  = ID_NOFWD;
        if (mem_ok && hz.num_write_MEM == hz.rs_EXE)     hz.s_a_FWD_EXE = MEM2EXE_FWD;
        else if (wb_ok && hz.num_write_WB == hz.rs_EXE)  hz.s_a_FWD_EXE = WB2EXE_FWD;
        if (mem_ok && hz.num_write_MEM == hz.rt_EXE)     hz.s_b_FWD_EXE = MEM2EXE_FWD;
        else if (wb_ok && hz.num_write_WB == hz.rt_EXE)  hz.s_b_FWD_EXE = WB2EXE_FWD;
        if (mem_ok && hz.num_write_MEM == hz.rs_ID)      hz.s_a_FWD_ID  = MEM2ID_FWD;
        else if (wb_ok && hz.num_write_WB == hz.rs_ID)   hz.s_a_FWD_ID  = WB2ID_FWD;
        if (mem_ok && hz.num_write_MEM == hz.rt_ID)      hz.s_b_FWD_ID  = MEM2ID_FWD;
        else if (wb_ok && hz.num_write_WB == hz.rt_ID)   hz.s_b_FWD_ID  = WB2ID_FWD;
    end

    // Raw stall and flush conditions, before priority resolution.
    always_comb begin
        is_br    = (hz.inst_type_ID == INST_BEQ) || (hz.inst_type_ID == INST_JR);
        br_stall = is_br &&
                   (((hz.num_write_EXE != REG_W'(0)) &&
                     (hz.num_write_EXE == hz.rs_ID || hz.num_write_EXE == hz.rt_ID)) ||
                    ((hz.inst_type_MEM == INST_LW) && (hz.num_write_MEM != REG_W'(0)) &&
                     (hz.num_write_MEM == hz.rs_ID || hz.num_write_MEM == hz.rt_ID)));
        lu_stall = (hz.inst_type_EXE == INST_LW) && (hz.num_write_EXE != REG_W'(0)) &&
                   ((hz.num_write_EXE == hz.rs_ID) ||
                    (hz.num_write_EXE == hz.rt_ID && !hz.s_b_ID));
        ctrl_flush = (hz.inst_type_ID == INST_J) || (hz.inst_type_ID == INST_JR) ||
                     ((hz.inst_type_ID == INST_BEQ) && hz.zero_ID);
    end

    // Priority: reset, mul/div freeze, branch/JR stall, load-use, control flush.
    always_comb begin
        hz.nWrite_PC     = 1'b0;
        hz.nWrite_IF_ID  = 1'b0;
        hz.nWrite_ID_EXE = 1'b0;
        hz.flush_IF_ID   = 1'b0;
        hz.flush_ID_EXE  = 1'b0;
        hz.flush_EXE_MEM = 1'b0;
        if (rst) begin
            hz.nWrite_PC = 1'b0;
        end else if (mc_stall) begin
            hz.nWrite_PC     = 1'b1;
            hz.nWrite_IF_ID  = 1'b1;
            hz.nWrite_ID_EXE = 1'b1;
            hz.flush_EXE_MEM = 1'b1;
        end else if (br_stall || lu_stall) begin
            hz.nWrite_PC    = 1'b1;
            hz.nWrite_IF_ID = 1'b1;
            hz.flush_ID_EXE = 1'b1;
        end else if (ctrl_flush) begin
            hz.flush_IF_ID = 1'b1;
        end
    end

    // Saturating count of PC-hold cycles.
    always_ff @(posedge clk) begin
        if (rst)                               cnt_q <= '0;
        else if (hz.nWrite_PC && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
    end

    assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc (MC_LAT=4, CNT_W=4).
module tb_hazard_ctrl_mc;
    import hazard_ctrl_mc_pkg::*;

    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    typedef struct {
        logic [4:0] rs_id, rt_id;
        logic       sb;
        logic [2:0] tid, texe, tmem;
        logic       z;
        logic [4:0] rs_exe, rt_exe, nw_exe;
        logic       rwm;
        logic [4:0] nwm;
        logic       rww;
        logic [4:0] nww;
        logic [1:0] fa_exe, fb_exe, fa_id, fb_id;
        logic [5:0] ctl;   // {nPC, nIF_ID, nID_EXE, fIF_ID, fID_EXE, fEXE_MEM}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(CNT_W)) bus ();

    hazard_ctrl_mc #(.REG_W(5), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {bus.nWrite_PC, bus.nWrite_IF_ID, bus.nWrite_ID_EXE,
                bus.flush_IF_ID, bus.flush_ID_EXE, bus.flush_EXE_MEM};
    endfunction

    task automatic apply(input vec_t v);
        bus.rs_ID = v.rs_id;          bus.rt_ID = v.rt_id;      bus.s_b_ID = v.sb;
        bus.inst_type_ID = v.tid;     bus.inst_type_EXE = v.texe;
        bus.inst_type_MEM = v.tmem;   bus.zero_ID = v.z;
        bus.rs_EXE = v.rs_exe;        bus.rt_EXE = v.rt_exe;    bus.num_write_EXE = v.nw_exe;
        bus.reg_write_MEM = v.rwm;    bus.num_write_MEM = v.nwm;
        bus.reg_write_WB = v.rww;     bus.num_write_WB = v.nww;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{5'd0, 5'd0, 1'b0, INST_R, INST_R, INST_R, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0, 6'd0};
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        apply(blank());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference forwarding choice: MEM result first, then WB, else none.
    function automatic logic [1:0] ref_fwd(input vec_t v, input logic [4:0] src);
        if (v.rwm && v.nwm != 0 && v.nwm == src) return 2'd1;
        if (v.rww && v.nww != 0 && v.nww == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic reads(input vec_t v, input logic [4:0] r);
        return r != 0 && (r == v.rs_id || r == v.rt_id);
    endfunction

    vec_t tbl[18];
    vec_t v;
    int   busy_rem;   // remaining cycles the unit is in BUSY (0 = idle)
    int   cnt_ref;

    initial begin
        // rs rt sb tid texe tmem z | rsE rtE nwE | rwM nwM rwW nwW | faE fbE faI fbI ctl
        tbl[0]  = '{1,2,0,INST_R,INST_R,INST_R,0,   3,0,0, 1,3,1,3, 1,0,0,0, 6'b000000};
        tbl[1]  = '{1,2,0,INST_R,INST_R,INST_R,0,   3,0,0, 0,3,1,3, 2,0,0,0, 6'b000000};
        tbl[2]  = '{0,2,0,INST_R,INST_R,INST_R,0,   0,0,0, 1,0,1,0, 0,0,0,0, 6'b000000};
        tbl[3]  = '{4,6,0,INST_R,INST_R,INST_R,0,   9,6,0, 1,4,1,6, 0,2,1,2, 6'b000000};
        tbl[4]  = '{1,5,0,INST_R,INST_LW,INST_R,0,  0,0,5, 0,0,0,0, 0,0,0,0, 6'b110010};
        tbl[5]  = '{1,5,1,INST_R,INST_LW,INST_R,0,  0,0,5, 0,0,0,0, 0,0,0,0, 6'b000000};
        tbl[6]  = '{5,2,1,INST_R,INST_LW,INST_R,0,  0,0,5, 0,0,0,0, 0,0,0,0, 6'b110010};
        tbl[7]  = '{0,0,0,INST_R,INST_LW,INST_R,0,  0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000};
        tbl[8]  = '{7,1,0,INST_BEQ,INST_R,INST_LW,0,0,0,0, 1,7,0,0, 0,0,1,0, 6'b110010};
        tbl[9]  = '{7,1,0,INST_BEQ,INST_R,INST_LW,1,0,0,0, 1,7,0,0, 0,0,1,0, 6'b110010};
        tbl[10] = '{7,1,0,INST_BEQ,INST_R,INST_R,1, 0,0,0, 0,0,0,0, 0,0,0,0, 6'b000100};
        tbl[11] = '{7,1,0,INST_BEQ,INST_R,INST_R,0, 0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000};
        tbl[12] = '{0,0,0,INST_J,INST_R,INST_R,0,   0,0,0, 0,0,0,0, 0,0,0,0, 6'b000100};
        tbl[13] = '{8,0,0,INST_JR,INST_R,INST_R,0,  0,0,8, 0,0,0,0, 0,0,0,0, 6'b110010};
        tbl[14] = '{8,0,0,INST_JR,INST_R,INST_R,0,  0,0,0, 0,0,0,0, 0,0,0,0, 6'b000100};
        tbl[15] = '{7,1,0,INST_BEQ,INST_R,INST_R,0, 0,0,0, 1,7,0,0, 0,0,1,0, 6'b000000};
        tbl[16] = '{5,2,0,INST_J,INST_LW,INST_R,0,  0,0,5, 0,0,0,0, 0,0,0,0, 6'b110010};
        tbl[17] = '{7,1,0,INST_BEQ,INST_LW,INST_R,1,0,0,7, 0,0,0,0, 0,0,0,0, 6'b110010};

        // Reset state: holds/flushes low and counter cleared while rst is high.
        rst = 1'b1;
        apply(blank());
        @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl_now()), 0);
        chk("reset_busy", 32'(bus.mc_busy), 0);
        chk("reset_cnt", 32'(bus.stall_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle vectors (no mul/div in EXE, FSM stays idle).
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_faE", i), 32'(bus.s_a_FWD_EXE), 32'(tbl[i].fa_exe));
            chk($sformatf("vec%0d_fbE", i), 32'(bus.s_b_FWD_EXE), 32'(tbl[i].fb_exe));
            chk($sformatf("vec%0d_faI", i), 32'(bus.s_a_FWD_ID),  32'(tbl[i].fa_id));
            chk($sformatf("vec%0d_fbI", i), 32'(bus.s_b_FWD_ID),  32'(tbl[i].fb_id));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()),       32'(tbl[i].ctl));
            @(posedge clk);
            #1;
        end

        // Mul/div occupancy: 3 stall cycles, BUSY in cycles 1..3, no retrigger.
        do_reset();
        v = blank();
        v.texe = INST_MULDIV;
        apply(v);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                v.texe = INST_R;
                apply(v);
            end
            @(negedge clk);
            chk($sformatf("md_c%0d_ctl", c), 32'(ctl_now()), (c < 3) ? 32'h39 : 32'h0);
            chk($sformatf("md_c%0d_busy", c), 32'(bus.mc_busy), (c >= 1 && c <= 3) ? 1 : 0);
            chk($sformatf("md_c%0d_cnt", c), 32'(bus.stall_cnt), (c < 3) ? c : 3);
            @(posedge clk);
            #1;
        end

        // Load-use during BUSY is masked by the freeze; reset mid-BUSY clears all.
        do_reset();
        v = blank();
        v.texe = INST_MULDIV;
        apply(v);
        @(posedge clk);
        #1;
        v.texe = INST_LW; v.nw_exe = 5; v.rs_id = 5; v.tid = INST_BEQ;
        apply(v);
        @(negedge clk);
        chk("md_lu_ctl", 32'(ctl_now()), 32'h39);
        chk("md_lu_busy", 32'(bus.mc_busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("md_rst_ctl", 32'(ctl_now()), 0);
        chk("md_rst_busy", 32'(bus.mc_busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(blank());
        @(negedge clk);
        chk("post_rst_ctl", 32'(ctl_now()), 0);
        chk("post_rst_busy", 32'(bus.mc_busy), 0);
        chk("post_rst_cnt", 32'(bus.stall_cnt), 0);

        // Counter saturation over 20 consecutive load-use stalls.
        do_reset();
        v = blank();
        v.texe = INST_LW; v.nw_exe = 5; v.rs_id = 5;
        apply(v);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat_k%0d", k), 32'(bus.stall_cnt), (k > CMAX) ? CMAX : k);
        end

        // Randomized run against the reference model.
        do_reset();
        busy_rem = 0;
        cnt_ref  = 0;
        for (int n = 0; n < 400; n++) begin
            vec_t r;
            logic [5:0] ectl;
            logic       mc, br, lu, cf, ebusy;
            r = blank();
            r.rs_id  = 5'($urandom_range(0, 7));  r.rt_id  = 5'($urandom_range(0, 7));
            r.sb     = 1'($urandom_range(0, 1));  r.z      = 1'($urandom_range(0, 1));
            r.tid    = 3'($urandom_range(0, 7));  r.tmem   = 3'($urandom_range(0, 6));
            r.texe   = ($urandom_range(0, 99) < 8) ? INST_MULDIV : 3'($urandom_range(0, 6));
            r.rs_exe = 5'($urandom_range(0, 7));  r.rt_exe = 5'($urandom_range(0, 7));
            r.nw_exe = 5'($urandom_range(0, 7));
            r.rwm    = 1'($urandom_range(0, 1));  r.nwm    = 5'($urandom_range(0, 7));
            r.rww    = 1'($urandom_range(0, 1));  r.nww    = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) < 3);
            apply(r);

            mc = !rst && (busy_rem > 1 || (busy_rem == 0 && r.texe == INST_MULDIV));
            br = (r.tid == INST_BEQ || r.tid == INST_JR) &&
                 (reads(r, r.nw_exe) || (r.tmem == INST_LW && reads(r, r.nwm)));
            lu = r.texe == INST_LW && r.nw_exe != 0 &&
                 (r.nw_exe == r.rs_id || (r.nw_exe == r.rt_id && !r.sb));
            cf = r.tid == INST_J || r.tid == INST_JR || (r.tid == INST_BEQ && r.z);
            if (rst)           ectl = 6'b000000;
            else if (mc)       ectl = 6'b111001;
            else if (br || lu) ectl = 6'b110010;
            else if (cf)       ectl = 6'b000100;
            else               ectl = 6'b000000;
            ebusy = !rst && busy_rem > 0;

            @(negedge clk);
            chk($sformatf("rnd%0d_faE", n), 32'(bus.s_a_FWD_EXE), 32'(ref_fwd(r, r.rs_exe)));
            chk($sformatf("rnd%0d_fbE", n), 32'(bus.s_b_FWD_EXE), 32'(ref_fwd(r, r.rt_exe)));
            chk($sformatf("rnd%0d_faI", n), 32'(bus.s_a_FWD_ID),  32'(ref_fwd(r, r.rs_id)));
            chk($sformatf("rnd%0d_fbI", n), 32'(bus.s_b_FWD_ID),  32'(ref_fwd(r, r.rt_id)));
            chk($sformatf("rnd%0d_ctl", n), 32'(ctl_now()), 32'(ectl));
            chk($sformatf("rnd%0d_busy", n), 32'(bus.mc_busy), 32'(ebusy));
            chk($sformatf("rnd%0d_cnt", n), 32'(bus.stall_cnt), cnt_ref);

            @(posedge clk);
            if (rst) begin
                busy_rem = 0;
                cnt_ref  = 0;
            end else begin
                if (ectl[5] && cnt_ref < CMAX) cnt_ref++;
                if (busy_rem > 0)                  busy_rem--;
                else if (r.texe == INST_MULDIV)    busy_rem = MC_LAT - 1;
            end
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
